fib_bcd_converter: RTL

Downstream consumer of the Fibonacci generator's fib_out term stream. Converts one WIDTH-bit unsigned binary term into packed BCD digits using an iterative shift-and-add-3 (double-dabble) datapath, one bit per cycle. Presents the result, with its significant-digit count, to the display/logging stage over a valid/ready handshake.

---
 rtl/fib_pkg.sv | 18 +
 rtl/fib_bcd_converter_if.sv | 44 ++++
 rtl/bcd_adj3.sv | 13 +
 rtl/fib_bcd_converter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: constants and types shared by the Fibonacci term pipeline.
//   FIB_WIDTH   - binary width of one Fibonacci term (matches fibonacci_gen)
//   BCD_DIGITS  - decimal digits needed to show any FIB_WIDTH-bit term
//   BCD_NDIG_W  - width of a significant-digit count (0..BCD_DIGITS)
//   fib_bcd_state_t - control states of the binary-to-BCD converter
package fib_pkg;

  localparam int FIB_WIDTH  = 64;
  localparam int BCD_DIGITS = 20;
  localparam int BCD_NDIG_W = $clog2(BCD_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } fib_bcd_state_t;

endpackage : fib_pkg

// File: rtl/fib_bcd_converter_if.sv
// fib_bcd_converter_if: input and result handshakes of fib_bcd_converter.
//   in_valid/in_ready/in_data            - binary term in (producer -> converter)
//   out_valid/out_ready/out_bcd/
//   out_ndigits                          - packed BCD result out (converter -> consumer)
// modport master: the side that supplies terms and consumes results.
// modport slave : the converter itself.
interface fib_bcd_converter_if
  import fib_pkg::*;
#(
  parameter int WIDTH  = FIB_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) ();

  localparam int NDIG_W = $clog2(DIGITS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [NDIG_W-1:0]     out_ndigits;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bcd,
    input  out_ndigits
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bcd,
    output out_ndigits
  );

endinterface : fib_bcd_converter_if

// File: rtl/bcd_adj3.sv
// bcd_adj3: one double-dabble correction cell.
//   digit_in  - BCD digit before the shift (0..9)
//   digit_out - digit_in + 3 when digit_in >= 5, otherwise digit_in
// Adding 3 before a left shift makes a digit of 5..9 carry into the next
// digit exactly when its doubled value reaches 10.
module bcd_adj3 (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule : bcd_adj3

// File: rtl/fib_bcd_converter.sv
// fib_bcd_converter: converts one WIDTH-bit unsigned term into DIGITS packed
// BCD digits, one binary bit per clock (shift-and-add-3).
//   clk     - clock, all state on the rising edge
//   reset   - asynchronous active-high reset, aborts any conversion
//   bus     - fib_bcd_converter_if.slave: term in, BCD result out
//   busy    - high while converting or holding a result
//   overrun - sticky: a term was offered while the block could not take it
// A term accepted at edge t gives out_valid after edge t+WIDTH; the result
// is held until the consumer takes it, and only then is a new term accepted.
module fib_bcd_converter
  import fib_pkg::*;
#(
  parameter int WIDTH  = FIB_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  fib_bcd_converter_if.slave  bus,
  output logic                busy,
  output logic                overrun
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int NDIG_W = $clog2(DIGITS + 1);
  // ceil(WIDTH * log10(2)) in integer arithmetic (log10(2) ~= 0.30103)
  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

  generate
    if (DIGITS < MIN_DIGITS) begin : g_digits_check
      $error("fib_bcd_converter: DIGITS=%0d too small for WIDTH=%0d (need %0d)",
             DIGITS, WIDTH, MIN_DIGITS);
    end
  endgenerate

  fib_bcd_state_t       state_reg, state_next;
  logic [WIDTH-1:0]     bin_reg;
  logic [BCD_W-1:0]     bcd_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [BCD_W-1:0]     out_bcd_reg;
  logic [NDIG_W-1:0]    out_ndigits_reg;
  logic                 overrun_reg;

  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_shift;
  logic [NDIG_W-1:0]    ndigits_calc;
  logic                 load_en;
  logic                 shift_en;
  logic                 finish_en;

  // Correct every digit, then shift the MSB of the binary register in.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_adj3 u_adj (
        .digit_in  (bcd_reg[gi*4 +: 4]),
        .digit_out (bcd_adj[gi*4 +: 4])
      );
    end
  endgenerate

  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_reg[WIDTH-1]};

  // Leading-digit scan over the value about to be registered as the result;
  // an all-zero result still reports one digit.
  always_comb begin
    ndigits_calc = NDIG_W'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] != 4'd0) begin
        ndigits_calc = NDIG_W'(i + 1);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and datapath enables
  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    finish_en  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          load_en    = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        shift_en = 1'b1;
        // cnt_reg==1 means this edge performs the final shift
        if (cnt_reg == CNT_W'(1)) begin
          finish_en  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Conversion datapath and result holding registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_reg         <= '0;
      bcd_reg         <= '0;
      cnt_reg         <= '0;
      out_bcd_reg     <= '0;
      out_ndigits_reg <= '0;
    end else begin
      if (load_en) begin
        bin_reg <= bus.in_data;
        bcd_reg <= '0;
        cnt_reg <= CNT_W'(WIDTH);
      end else if (shift_en) begin
        bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
        bcd_reg <= bcd_shift;
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (finish_en) begin
        out_bcd_reg     <= bcd_shift;
        out_ndigits_reg <= ndigits_calc;
      end
    end
  end

  // Overrun flag: only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else if (bus.in_valid && (state_reg != IDLE)) begin
      overrun_reg <= 1'b1;
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.out_bcd     = out_bcd_reg;
  assign bus.out_ndigits = out_ndigits_reg;
  assign busy            = (state_reg != IDLE);
  assign overrun         = overrun_reg;

endmodule : fib_bcd_converter
